// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nibble_serial_add_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_adder4.sv
// Combinational 4-bit ripple adder slice; c3 is the carry into the top bit,
// exposed so the controller can derive signed overflow.
module nibble_adder4
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout,
    output logic             c3
);

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        logic [NIB_W:0] c;
        c    = '0;
        c[0] = cin;
        sum  = '0;
        for (int i = 0; i < NIB_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[NIB_W];
        c3   = c[NIB_W-1];
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller: one 4-bit slice, LSB nibble first,
// valid/ready handshakes on both sides.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new operation; result regs hold the last result
// RUN   | one nibble per cycle through the shared slice
// DONE  | result presented, held until the consumer accepts it
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NNIB = 4
)
(
    input  logic                  CK,
    input  logic                  RSTN,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [NIB_W*NNIB-1:0] A,
    input  logic [NIB_W*NNIB-1:0] B,
    input  logic                  CIN,
    input  logic                  SUB,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [NIB_W*NNIB-1:0] SUM,
    output logic                  COUT,
    output logic                  OVF,
    output logic                  BUSY
);

    localparam int W  = NIB_W * NNIB;
    localparam int CW = cnt_width(NNIB);
    localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic              carry;
    logic              accept;
    logic              last;
    logic [NIB_W-1:0]  op_a;
    logic [NIB_W-1:0]  op_b;
    logic [NIB_W-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_c3;

    assign last = (cnt == LAST);

    // State register.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs; all status outputs decode the state.
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                BUSY = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select the current nibble of each operand for the shared slice.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NNIB; i++) begin
            if (cnt == CW'(i)) begin
                op_a = a_reg[i*NIB_W +: NIB_W];
                op_b = b_reg[i*NIB_W +: NIB_W];
            end
        end
    end

    nibble_adder4 u_slice (
        .a    (op_a),
        .b    (op_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    // Operand capture on accept, then one nibble per RUN cycle into SUM.
    // Subtraction is folded in here: B is inverted and the carry seeded to 1.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            SUM   <= '0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= SUB ? ~B : B;
            carry <= SUB ? 1'b1 : CIN;
            cnt   <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NNIB; i++) begin
                if (cnt == CW'(i)) SUM[i*NIB_W +: NIB_W] <= slice_sum;
            end
            carry <= slice_cout;
            if (last) begin
                cnt  <= '0;
                COUT <= slice_cout;
                OVF  <= slice_c3 ^ slice_cout;
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl with NNIB=4.
module tb_nibble_serial_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic          CK = 1'b0;
    logic          RSTN;
    logic          IN_VALID;
    logic          IN_READY;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          CIN;
    logic          SUB;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [W-1:0]  SUM;
    logic          COUT;
    logic          OVF;
    logic          BUSY;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int rdy_mode = 0;          // 0 random, 1 hold low, 2 hold high

    logic [W+1:0] exp_q[$];    // {sum, cout, ovf}
    int           lat_q[$];    // cycle count expected at OUT_VALID rise

    logic         prev_ov = 1'b0;
    logic         expect_idle = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout;
    logic         hold_ovf;

    nibble_serial_add_ctrl #(.NNIB(N)) dut (
        .CK        (CK),
        .RSTN      (RSTN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .SUB       (SUB),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .COUT      (COUT),
        .OVF       (OVF),
        .BUSY      (BUSY)
    );

    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: true signed/unsigned arithmetic on whole operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        int sa, sb, sr, ua, ub, ur;
        logic [W-1:0] s;
        logic co, ov;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        if (sub) begin
            sr = sa - sb;
            ur = ua - ub;
            co = (ua >= ub);
        end else begin
            sr = sa + sb + int'(cin);
            ur = ua + ub + int'(cin);
            co = (ur > 65535);
        end
        s  = ur[W-1:0];
        ov = (sr > 32767) || (sr < -32768);
        return {s, co, ov};
    endfunction

    // Consumer-side ready pattern.
    always @(posedge CK) begin
        #1;
        case (rdy_mode)
            0:       OUT_READY = 1'($urandom_range(0, 1));
            1:       OUT_READY = 1'b0;
            default: OUT_READY = 1'b1;
        endcase
    end

    // Monitor: latency, hold stability and result comparison.
    always @(negedge CK) begin
        if (!RSTN) begin
            prev_ov     = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                chk("idle_after_ack", IN_READY && !OUT_VALID, {30'd0, IN_READY, OUT_VALID}, 32'h2);
                expect_idle = 1'b0;
            end
            if (OUT_VALID) begin
                chk("in_ready_in_done", !IN_READY, IN_READY, 0);
                if (!prev_ov) begin
                    chk("out_expected", lat_q.size() > 0, lat_q.size(), 1);
                    if (lat_q.size() > 0) begin
                        int l;
                        l = lat_q.pop_front();
                        chk("latency", (cyc - l) == N, cyc - l, N);
                    end
                    hold_sum  = SUM;
                    hold_cout = COUT;
                    hold_ovf  = OVF;
                end else begin
                    chk("hold_stable", {SUM, COUT, OVF} === {hold_sum, hold_cout, hold_ovf},
                        {14'd0, SUM, COUT, OVF}, {14'd0, hold_sum, hold_cout, hold_ovf});
                end
                if (OUT_READY) begin
                    chk("result_queued", exp_q.size() > 0, exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        logic [W+1:0] e;
                        e = exp_q.pop_front();
                        chk("sum",  SUM  === e[W+1:2], SUM,  e[W+1:2]);
                        chk("cout", COUT === e[1],     COUT, e[1]);
                        chk("ovf",  OVF  === e[0],     OVF,  e[0]);
                    end
                    expect_idle = 1'b1;
                end
            end
            prev_ov = OUT_VALID;
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int n;
        n = 0;
        @(posedge CK); #1;
        A = a; B = b; CIN = cin; SUB = sub; IN_VALID = 1'b1;
        while (!IN_READY && n < 100) begin
            @(posedge CK); #1;
            n++;
        end
        chk("accept_wait", IN_READY, IN_READY, 1);
        if (!IN_READY) begin
            IN_VALID = 1'b0;
            return;
        end
        exp_q.push_back(model(a, b, cin, sub));
        lat_q.push_back(cyc + 1);
        @(posedge CK); #1;
        IN_VALID = 1'b0;
        chk("busy_in_run", BUSY === 1'b1, BUSY, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge CK);
            n++;
        end
        chk("drain", exp_q.size() == 0, exp_q.size(), 0);
    endtask

    initial begin
        RSTN = 1'b0; IN_VALID = 1'b0; A = '0; B = '0; CIN = 1'b0; SUB = 1'b0; OUT_READY = 1'b0;
        #12;
        chk("rst_in_ready", IN_READY === 1'b1, IN_READY, 1);
        chk("rst_outs", {OUT_VALID, BUSY, COUT, OVF} === 4'b0, {OUT_VALID, BUSY, COUT, OVF}, 0);
        chk("rst_sum", SUM === '0, SUM, 0);
        #11 RSTN = 1'b1;

        // Directed vectors.
        rdy_mode = 2;
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_drain();

        // Back-pressure with an ignored request during DONE.
        rdy_mode = 1;
        do_op(16'hABCD, 16'h1111, 1'b1, 1'b0);
        begin
            int n;
            n = 0;
            while (!OUT_VALID && n < 20) begin
                @(posedge CK); #1;
                n++;
            end
            chk("bp_valid_seen", OUT_VALID, OUT_VALID, 1);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                A = 16'h5555; B = 16'h2222; CIN = 1'b0; SUB = 1'b1; IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            chk("bp_in_ready_low", IN_READY === 1'b0, IN_READY, 0);
            @(posedge CK); #1;
        end
        IN_VALID = 1'b0;
        rdy_mode = 2;
        wait_drain();
        repeat (3) @(posedge CK);

        // Reset while cnt=2.
        rdy_mode = 0;
        do_op(16'h4321, 16'h1234, 1'b0, 1'b0);
        @(posedge CK);
        @(posedge CK); #2;
        RSTN = 1'b0;
        exp_q.delete();
        lat_q.delete();
        #1;
        chk("mid_rst_in_ready", IN_READY === 1'b1, IN_READY, 1);
        chk("mid_rst_outs", {OUT_VALID, BUSY, COUT, OVF} === 4'b0, {OUT_VALID, BUSY, COUT, OVF}, 0);
        chk("mid_rst_sum", SUM === '0, SUM, 0);
        repeat (2) @(posedge CK);
        #3 RSTN = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (8) begin
                @(negedge CK);
                if (OUT_VALID) seen = 1'b1;
            end
            chk("no_out_after_rst", !seen, seen, 0);
        end

        // New operation straight after reset release.
        @(posedge CK); #1;
        RSTN = 1'b0;
        #3 RSTN = 1'b1;
        do_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rdy_mode = 2;
        wait_drain();
        repeat (3) @(posedge CK);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 SHALL have parameter NNIB, default 4, meaning the number of 4-bit nibbles per operand (legal range 2..16).
REQ-002 SHALL have port CK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port IN_VALID, input, 1 bit: operands and mode are valid.
REQ-005 SHALL have port IN_READY, output, 1 bit: block can accept an operation.
REQ-006 SHALL have ports A and B, input, 4*NNIB bits each: operands.
REQ-007 SHALL have port CIN, input, 1 bit: carry-in, used when SUB=0.
REQ-008 SHALL have port SUB, input, 1 bit: 0 selects A+B+CIN; 1 selects A-B, computed as A+~B+1 with CIN ignored.
REQ-009 SHALL have port OUT_VALID, output, 1 bit: result is valid.
REQ-010 SHALL have port OUT_READY, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port SUM, output, 4*NNIB bits: result.
REQ-012 SHALL have port COUT, output, 1 bit: final carry out (for SUB: 1 means no borrow).
REQ-013 SHALL have port OVF, output, 1 bit: two's-complement signed overflow.
REQ-014 SHALL have port BUSY, output, 1 bit: high in RUN state.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL drive IN_READY=1 only in IDLE; an operation is accepted on a rising edge where IN_VALID=1 and IN_READY=1.
REQ-017 SHALL, on accept, register A, ~B if SUB else B, and a carry of 1 if SUB else CIN; clear the nibble counter to 0; and enter RUN.
REQ-018 SHALL, in each RUN cycle, add operand nibble[cnt] + B nibble[cnt] + carry register through one 4-bit adder slice, write the slice sum into SUM nibble[cnt], write the slice carry-out into the carry register, and increment cnt.
REQ-019 SHALL process nibbles LSB first, exactly one per cycle, using no more than one adder slice.
REQ-020 SHALL leave RUN for DONE on the edge that processes nibble NNIB-1, so OUT_VALID rises exactly NNIB cycles after the accept edge.
REQ-021 SHALL, in DONE, hold OUT_VALID=1 and keep SUM, COUT and OVF stable until an edge with OUT_READY=1, then return to IDLE.
REQ-022 SHALL set COUT to the carry register after the final nibble.
REQ-023 SHALL set OVF to the carry into bit 4*NNIB-1 XOR the carry out of bit 4*NNIB-1, captured during the final nibble.
REQ-024 SHALL ignore IN_VALID outside IDLE; operands presented during RUN or DONE are not captured.
REQ-025 SHALL treat OUT_READY=1 outside DONE as having no effect.
REQ-026 SHALL keep SUM, COUT and OVF holding the last completed result in IDLE; their values are unspecified while in RUN.
REQ-027 SHALL wrap the counter width of clog2(NNIB) bits only via the RUN-to-DONE transition; cnt is never allowed to overflow.

Reset
REQ-028 SHALL, while RSTN=0, asynchronously force state to IDLE, cnt=0, carry register=0, SUM=0, COUT=0, OVF=0, OUT_VALID=0 and BUSY=0.
REQ-029 SHALL drive IN_READY=1 one delta after RSTN falls, i.e. IN_READY follows the IDLE state.
REQ-030 SHALL, on reset asserted mid-RUN or mid-DONE, abort the operation and produce no result once RSTN deasserts.
REQ-031 SHALL accept a new operation starting on the first rising edge after RSTN deasserts.

Structure
REQ-032 SHALL place in a shared package: the state enumeration (IDLE/RUN/DONE), the nibble width constant 4, and the counter-width function.
REQ-033 SHALL contain exactly one sub-module: nibble_adder4, a combinational 4-bit ripple adder with ports a, b, cin, sum, cout and c3 (the carry into bit 3, needed for OVF).
REQ-034 SHALL make all other logic (FSM, operand shift/select, result registers) local to nibble_serial_add_ctrl.

Verification (NNIB=4)
REQ-035 SHALL cover: A=0x1234, B=0x0FFF, CIN=0, SUB=0 -> SUM=0x2233, COUT=0, OVF=0, with OUT_VALID rising 4 cycles after accept.
REQ-036 SHALL cover: A=0xFFFF, B=0x0001, CIN=0, SUB=0 -> SUM=0x0000, COUT=1, OVF=0 (carry rippling through all nibbles).
REQ-037 SHALL cover: A=0x0005, B=0x0007, SUB=1, CIN=1 -> SUM=0xFFFE, COUT=0, OVF=0 (CIN ignored).
REQ-038 SHALL cover: A=0x7FFF, B=0x0001, CIN=0, SUB=0 -> SUM=0x8000, OVF=1, COUT=0.
REQ-039 SHALL cover back-pressure: OUT_READY held at 0 for 5 cycles after OUT_VALID -> SUM stable and IN_READY=0 throughout, with a second IN_VALID in that window ignored; OUT_READY=1 -> IDLE on the next edge.
REQ-040 SHALL cover reset mid-operation: RSTN pulsed low during cnt=2 -> all outputs 0 and IN_READY=1 immediately, and no OUT_VALID afterwards.
